// File: rtl/fix_conv_arbiter_if.sv
// Bundle of request, converter and response signals around fix_conv_arbiter.
// slave is the arbiter's view; master is the requester/converter side.
interface fix_conv_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_float;
  logic [5*NUM_REQ-1:0]  req_pos;
  logic [31:0]           conv_float;
  logic [4:0]            conv_pos;
  logic [31:0]           conv_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_float, req_pos, conv_result, rsp_ready,
    output req_ready, conv_float, conv_pos, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport master (
    output req_valid, req_float, req_pos, conv_result, rsp_ready,
    input  req_ready, conv_float, conv_pos, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/fix_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one float-to-fixed converter among NUM_REQ requesters.
// Optional FIX_SAT_CHECK_EN: saturate Inf/NaN operands and flag them on rsp_err.
//
// state | meaning
// IDLE  | search for a request from rr_ptr, grant it and latch its operands
// WAIT  | converter busy; cnt counts down CONV_LATENCY cycles, capture at cnt==1
// RESP  | rsp_valid held until rsp_ready; then advance rr_ptr past the owner
module fix_conv_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CONV_LATENCY = 2,
  parameter int IDW          = 2
) (
  input  logic              clk,
  input  logic              rst,
  fix_conv_arbiter_if.slave bus
);
  localparam int CW = (CONV_LATENCY < 1) ? 1 : $clog2(CONV_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     rsp_id_q;
  logic [CW-1:0]      cnt;
  logic [31:0]        conv_float_q;
  logic [4:0]         conv_pos_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_valid_q;

  logic               gnt_found;
  logic [IDW-1:0]     gnt_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [31:0]        sel_float;
  logic [4:0]         sel_pos;
  logic [IDW-1:0]     next_ptr;
  logic               cap_en;
  logic [31:0]        cap_data;
  logic               cap_err;
  int                 idx;

  // Walk downward so the lowest offset from rr_ptr is written last and wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_c = '0;
    if (state == IDLE && gnt_found) req_ready_c[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_float = bus.req_float[int'(gnt_idx)*32 +: 32];
    sel_pos   = bus.req_pos[int'(gnt_idx)*5 +: 5];
  end

  assign next_ptr = (rsp_id_q == IDW'(NUM_REQ - 1)) ? '0 : rsp_id_q + IDW'(1);
  assign cap_en   = (state == WAIT) && (cnt == CW'(1));

`ifdef FIX_SAT_CHECK_EN
  logic rsp_err_q;
  logic sat;

  // Exponent all ones: the converter result is meaningless, clamp by sign.
  assign sat      = (conv_float_q[30:23] == 8'hFF);
  assign cap_data = sat ? (conv_float_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : bus.conv_result;
  assign cap_err  = sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rsp_err_q <= 1'b0;
    else if (cap_en) rsp_err_q <= cap_err;
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign cap_data    = bus.conv_result;
  assign cap_err     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      rsp_id_q     <= '0;
      cnt          <= '0;
      conv_float_q <= '0;
      conv_pos_q   <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            conv_float_q <= sel_float;
            conv_pos_q   <= sel_pos;
            rsp_id_q     <= gnt_idx;
            cnt          <= CW'(CONV_LATENCY);
            state        <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cap_en) begin
            rsp_data_q  <= cap_data;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.conv_float = conv_float_q;
  assign bus.conv_pos   = conv_pos_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
endmodule

// File: tb/tb_fix_conv_arbiter.sv
// Directed bench for fix_conv_arbiter with a CONV_LATENCY=2 adder stub as converter.
module tb_fix_conv_arbiter;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] conv_q;

  always #5 clk = ~clk;

  fix_conv_arbiter_if #(.NUM_REQ(4), .IDW(2)) bus();

  fix_conv_arbiter #(.NUM_REQ(4), .CONV_LATENCY(2), .IDW(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // One register after the grant edge plus the capture edge = 2 cycles of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) conv_q <= '0;
    else      conv_q <= bus.conv_float + {27'd0, bus.conv_pos};
  end
  assign bus.conv_result = conv_q;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] f, input logic [4:0] p);
    bus.req_float[32*i +: 32] = f;
    bus.req_pos[5*i +: 5] = p;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    bus.req_float = '0;
    bus.req_pos = '0;
    cyc(2);
    #1;
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    vectors++; if (bus.rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
    vectors++; if (bus.rsp_id !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
    vectors++; if (bus.conv_float !== 32'h0 || bus.conv_pos !== 5'd0) begin miscompares++; $display("FAIL reset_conv got %h/%0d want 0/0", bus.conv_float, bus.conv_pos); end
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    cyc(1);
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic test_round_robin;
    logic [31:0] f [4];
    logic [4:0]  p [4];
    for (int i = 0; i < 4; i++) begin
      f[i] = 32'h4100_0000 + 32'(i * 256);
      p[i] = 5'(i + 4);
      set_req(i, f[i], p[i]);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      #1;
      vectors++; if (bus.req_ready !== 4'(1 << g)) begin miscompares++; $display("FAIL rr_grant%0d got %b want %b", n, bus.req_ready, 4'(1 << g)); end
      cyc(1);
      if (n == 4) bus.req_valid = '0;
      #1;
      vectors++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rr_wait%0d got ready %b valid %b want 0000 0", n, bus.req_ready, bus.rsp_valid); end
      cyc(2);
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(g) || bus.rsp_data !== f[g] + 32'(p[g])) begin
        miscompares++; $display("FAIL rr_rsp%0d got v%b id%0d %h want v1 id%0d %h", n, bus.rsp_valid, bus.rsp_id, bus.rsp_data, g, f[g] + 32'(p[g]));
      end
      cyc(1);
    end
  endtask

  task automatic test_single;
    set_req(2, 32'h3F80_0000, 5'd3);
    bus.req_valid = 4'b0100;
    #1;
    vectors++; if (bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready got %b want 0100", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    #1;
    vectors++; if (bus.conv_float !== 32'h3F80_0000 || bus.conv_pos !== 5'd3) begin miscompares++; $display("FAIL single_conv got %h/%0d want 3f800000/3", bus.conv_float, bus.conv_pos); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early1 got %b want 0", bus.rsp_valid); end
    cyc(1);
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early2 got %b want 0", bus.rsp_valid); end
    cyc(1);
    vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h3F80_0003 || bus.rsp_id !== 2'd2 || bus.rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL single_rsp got v%b %h id%0d e%b want v1 3f800003 id2 e0", bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err);
    end
    cyc(1);
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_drop got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_stall;
    set_req(0, 32'h1234_5600, 5'd31);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL stall_wrap_grant got %b want 0001", bus.req_ready); end
    cyc(1);
    bus.req_valid = 4'b0100;
    cyc(2);
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1234_561F || bus.rsp_id !== 2'd0 || bus.req_ready !== 4'b0000) begin
        miscompares++; $display("FAIL stall_hold%0d got v%b %h id%0d rdy%b want v1 1234561f id0 rdy0000", c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready);
      end
      cyc(1);
    end
    bus.rsp_ready = 1'b1;
    cyc(1);
    #1;
    vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin miscompares++; $display("FAIL stall_release got v%b rdy%b want v0 rdy0100", bus.rsp_valid, bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    cyc(2);
    vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 32'h3F80_0003) begin
      miscompares++; $display("FAIL stall_next got v%b id%0d %h want v1 id2 3f800003", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    cyc(1);
  endtask

  task automatic test_drop_pulse;
    set_req(3, 32'h0000_0100, 5'd1);
    set_req(1, 32'h0000_0200, 5'd2);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    #1;
    vectors++; if (bus.req_ready !== 4'b1000) begin miscompares++; $display("FAIL pulse_grant got %b want 1000", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    cyc(4);
    bus.req_valid = 4'b0010;
    #1;
    vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL pulse_ready got %b want 0000", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    #1;
    vectors++; if (bus.rsp_id !== 2'd3 || bus.rsp_data !== 32'h0000_0101) begin miscompares++; $display("FAIL pulse_owner got id%0d %h want id3 00000101", bus.rsp_id, bus.rsp_data); end
    cyc(2);
    bus.rsp_ready = 1'b1;
    cyc(1);
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL pulse_ghost%0d got v%b rdy%b want v0 rdy0000", c, bus.rsp_valid, bus.req_ready); end
      cyc(1);
    end
  endtask

  task automatic test_reset_mid;
    bus.req_valid = 4'b0100;
    cyc(1);
    bus.req_valid = '0;
    cyc(3);
    bus.req_valid = 4'b1000;
    #1;
    vectors++; if (bus.req_ready !== 4'b1000) begin miscompares++; $display("FAIL rmid_grant got %b want 1000", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    rst = 1'b0;
    #1;
    vectors++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL rmid_rsp got v%b %h id%0d e%b want all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err);
    end
    vectors++; if (bus.conv_float !== 32'h0 || bus.conv_pos !== 5'd0) begin miscompares++; $display("FAIL rmid_conv got %h/%0d want 0/0", bus.conv_float, bus.conv_pos); end
    cyc(2);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_ghost%0d got %b want 0", c, bus.rsp_valid); end
    end
    bus.req_valid = 4'b1001;
    #1;
    vectors++; if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_ptr got %b want 0001", bus.req_ready); end
    cyc(1);
    bus.req_valid = '0;
    cyc(2);
    vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 32'h1234_561F) begin
      miscompares++; $display("FAIL rmid_rsp0 got v%b id%0d %h want v1 id0 1234561f", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    cyc(1);
  endtask

  task automatic test_sat;
    logic [31:0] fv [3];
    logic [4:0]  pv [3];
    logic [31:0] ed [3];
    logic        ee [3];
    fv[0] = 32'hFF80_0000; pv[0] = 5'd4;
    fv[1] = 32'h7FC0_0000; pv[1] = 5'd1;
    fv[2] = 32'h3F80_0000; pv[2] = 5'd2;
`ifdef FIX_SAT_CHECK_EN
    ed[0] = 32'h8000_0000; ee[0] = 1'b1;
    ed[1] = 32'h7FFF_FFFF; ee[1] = 1'b1;
`else
    ed[0] = 32'hFF80_0004; ee[0] = 1'b0;
    ed[1] = 32'h7FC0_0001; ee[1] = 1'b0;
`endif
    ed[2] = 32'h3F80_0002; ee[2] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_req(n + 1, fv[n], pv[n]);
      bus.req_valid = 4'(1 << (n + 1));
      #1;
      vectors++; if (bus.req_ready !== 4'(1 << (n + 1))) begin miscompares++; $display("FAIL sat_grant%0d got %b want %b", n, bus.req_ready, 4'(1 << (n + 1))); end
      cyc(1);
      bus.req_valid = '0;
      cyc(2);
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ed[n] || bus.rsp_err !== ee[n] || bus.rsp_id !== 2'(n + 1)) begin
        miscompares++; $display("FAIL sat_rsp%0d got v%b %h e%b id%0d want v1 %h e%b id%0d", n, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_id, ed[n], ee[n], n + 1);
      end
      cyc(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_drop_pulse();
    test_reset_mid();
    test_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
